servant_clock_gate_ctrl: RTL

//   Drives the clock-enable inputs (i_clk0_en/i_clk1_en) of the board clock generator.

---
 rtl/servant_clock_gate_ctrl.sv | 92 +++++++++
 1 files changed

// File: rtl/servant_clock_gate_ctrl.sv
// Clock-gate sequencer for the two board clock enables: drains clk1 activity,
// gates clk1 then clk0, and ungates in reverse order on wake.
module servant_clock_gate_ctrl #(
   parameter int unsigned DRAIN = 8,
   parameter int unsigned GAP   = 4
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_sleep_req,
   input  logic        i_busy,
   input  logic        i_wake,
   output logic        o_clk0_en,
   output logic        o_clk1_en,
   output logic        o_asleep,
   output logic [15:0] o_sleep_cycles
);

   localparam int unsigned MAXC = (DRAIN > GAP) ? DRAIN : GAP;
   localparam int unsigned CW   = (MAXC < 2) ? 1 : $clog2(MAXC);

   localparam logic [CW-1:0] DRAIN_LAST = CW'(DRAIN - 1);
   localparam logic [CW-1:0] GAP_LAST   = CW'(GAP - 1);

   typedef enum logic [2:0] {
      ST_RUN,
      ST_DRAIN,
      ST_GATE1,
      ST_SLEEP,
      ST_WAKE0
   } state_t;

   state_t        state, state_next;
   logic [CW-1:0] cnt, cnt_next;
   logic          en0_next, en1_next, asleep_next;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      state_next = state;
      cnt_next   = '0;
      unique case (state)
         ST_RUN: begin
            if (i_sleep_req && !i_wake) state_next = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (i_wake)                               state_next = ST_RUN;
            else if (!i_busy && cnt == DRAIN_LAST)    state_next = ST_GATE1;
            else if (!i_busy)                         cnt_next   = cnt + 1'b1;
         end
         ST_GATE1: begin
            if (i_wake)                state_next = ST_WAKE0;
            else if (cnt == GAP_LAST)  state_next = ST_SLEEP;
            else                       cnt_next   = cnt + 1'b1;
         end
         ST_SLEEP: begin
            if (i_wake) state_next = ST_WAKE0;
         end
         ST_WAKE0: begin
            if (cnt == GAP_LAST) state_next = ST_RUN;
            else                 cnt_next   = cnt + 1'b1;
         end
         default: state_next = ST_RUN;
      endcase

      // Enables are decoded from the next state so the flops match the state register.
      en0_next    = (state_next != ST_SLEEP);
      en1_next    = (state_next == ST_RUN) || (state_next == ST_DRAIN);
      asleep_next = (state_next == ST_SLEEP);
   end

   // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state          <= ST_RUN;
         cnt            <= '0;
         o_clk0_en      <= 1'b1;
         o_clk1_en      <= 1'b1;
         o_asleep       <= 1'b0;
         o_sleep_cycles <= '0;
      end else begin
         state     <= state_next;
         cnt       <= cnt_next;
         o_clk0_en <= en0_next;
         o_clk1_en <= en1_next;
         o_asleep  <= asleep_next;
         if (state != ST_SLEEP && state_next == ST_SLEEP)
            o_sleep_cycles <= '0;
         else if (state == ST_SLEEP && o_sleep_cycles != 16'hFFFF)
            o_sleep_cycles <= o_sleep_cycles + 16'd1;
      end
   end

endmodule
